// File: rtl/fetch_ctrl_if.sv
// Decode/exception redirect, instruction port and IF/ID delivery signals of the fetch sequencer.
// master = fetch_ctrl side, slave = surrounding core / memory side.
interface fetch_ctrl_if;
   localparam int unsigned AW = 32;

   logic          br_taken;
   logic [AW-1:0] br_pc;
   logic [AW-1:0] br_target;
   logic          exc_flush;
   logic [AW-1:0] exc_target;
   logic          inst_req;
   logic [AW-1:0] inst_addr;
   logic          inst_addr_ok;
   logic          inst_data_ok;
   logic [AW-1:0] inst_rdata;
   logic          id_allowin;
   logic          fs_valid;
   logic [AW-1:0] fs_pc;
   logic [AW-1:0] fs_inst;

   modport master (
      input  br_taken, br_pc, br_target, exc_flush, exc_target,
             inst_addr_ok, inst_data_ok, inst_rdata, id_allowin,
      output inst_req, inst_addr, fs_valid, fs_pc, fs_inst
   );

   modport slave (
      output br_taken, br_pc, br_target, exc_flush, exc_target,
             inst_addr_ok, inst_data_ok, inst_rdata, id_allowin,
      input  inst_req, inst_addr, fs_valid, fs_pc, fs_inst
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one request in flight and applies
// delay-slot branch redirects and interrupt/ERET flushes.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic         clk,
   input  logic         resetn,
   fetch_ctrl_if.master bus
);
   localparam int unsigned AW = 32;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_req_addr;
   logic          r_pend_valid;
   logic [AW-1:0] r_pend_br_pc;
   logic [AW-1:0] r_pend_target;
   logic          r_cancel;
   logic [AW-1:0] r_fs_pc;
   logic [AW-1:0] r_fs_inst;

   logic          w_transfer;
   logic          w_data_take;
   logic          w_eff_pend_valid;
   logic [AW-1:0] w_eff_br_pc;
   logic [AW-1:0] w_eff_target;
   logic          w_take_target;
   logic [AW-1:0] w_next_addr;

   // state register
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_REQ;
      else         r_state <= w_state_nxt;
   end

   // next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_REQ:   if (bus.inst_addr_ok) w_state_nxt = S_WAIT;
         S_WAIT:  if (bus.inst_data_ok)
                     w_state_nxt = (r_cancel || bus.exc_flush) ? S_REQ : S_HOLD;
         S_HOLD:  if (bus.exc_flush || bus.id_allowin) w_state_nxt = S_REQ;
         default: w_state_nxt = S_REQ;
      endcase
   end

   // outputs; a flush in S_REQ retargets the pending request in the same cycle
   always_comb begin
      bus.inst_req  = 1'b0;
      bus.inst_addr = r_req_addr;
      bus.fs_valid  = 1'b0;
      case (r_state)
         S_REQ: begin
            bus.inst_req = resetn;
            if (bus.exc_flush) bus.inst_addr = bus.exc_target;
         end
         S_HOLD:  bus.fs_valid = ~bus.exc_flush;
         default: ;
      endcase
   end

   assign bus.fs_pc   = r_fs_pc;
   assign bus.fs_inst = r_fs_inst;

   assign w_transfer  = (r_state == S_HOLD) && bus.id_allowin && !bus.exc_flush;
   assign w_data_take = (r_state == S_WAIT) && bus.inst_data_ok;

   // a branch resolved in the transfer cycle takes part in the next-address decision
   assign w_eff_pend_valid = bus.br_taken | r_pend_valid;
   assign w_eff_br_pc      = bus.br_taken ? bus.br_pc     : r_pend_br_pc;
   assign w_eff_target     = bus.br_taken ? bus.br_target : r_pend_target;
   assign w_take_target    = w_eff_pend_valid && (r_req_addr == w_eff_br_pc + AW'(4));
   assign w_next_addr      = w_take_target ? w_eff_target : r_req_addr + AW'(4);

   // fetch address, pending redirect, cancel flag and delivered instruction
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_req_addr    <= RESET_PC;
         r_pend_valid  <= 1'b0;
         r_pend_br_pc  <= '0;
         r_pend_target <= '0;
         r_cancel      <= 1'b0;
         r_fs_pc       <= '0;
         r_fs_inst     <= '0;
      end else if (bus.exc_flush) begin
         r_req_addr   <= bus.exc_target;
         r_pend_valid <= 1'b0;
         r_cancel     <= (r_state == S_WAIT) && !bus.inst_data_ok;
      end else begin
         if (w_transfer) begin
            r_req_addr   <= w_next_addr;
            r_pend_valid <= w_eff_pend_valid && !w_take_target;
         end else if (bus.br_taken) begin
            r_pend_valid <= 1'b1;
         end
         if (bus.br_taken) begin
            r_pend_br_pc  <= bus.br_pc;
            r_pend_target <= bus.br_target;
         end
         if (w_data_take) begin
            r_cancel <= 1'b0;
            if (!r_cancel) begin
               r_fs_pc   <= r_req_addr;
               r_fs_inst <= bus.inst_rdata;
            end
         end
      end
   end
endmodule
